// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing and FSM encoding for the register-file write scoreboard.
package regfile_scoreboard_pkg;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;
    localparam int WB_BYP = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {SB_RUN, SB_DRAIN, SB_DONE, SB_HOLD} sb_state_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback/drain bundle between pipeline control and the scoreboard.
interface regfile_scoreboard_if;
    import regfile_scoreboard_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic [REG_AW-1:0] rs1;
    logic              rs1_used;
    logic [REG_AW-1:0] rs2;
    logic              rs2_used;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              retire_valid;
    logic [REG_AW-1:0] retire_rd;
    logic              kill_valid;
    logic [REG_AW-1:0] kill_rd;
    logic              drain_req;
    logic              drain_done;
    logic [NREG-1:0]   busy_vec;
    logic [31:0]       stall_cnt;
    logic              err;

    modport master (
        output issue_valid, rs1, rs1_used, rs2, rs2_used, rd, rd_we,
               retire_valid, retire_rd, kill_valid, kill_rd, drain_req,
        input  issue_ready, drain_done, busy_vec, stall_cnt, err
    );
    modport slave (
        input  issue_valid, rs1, rs1_used, rs2, rs2_used, rd, rd_we,
               retire_valid, retire_rd, kill_valid, kill_rd, drain_req,
        output issue_ready, drain_done, busy_vec, stall_cnt, err
    );
endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register in-flight write counter; net of one increment and two decrements per cycle,
// clamped to [0, CNT_MAX], flagging any attempt to go below zero.
module sb_counter
    import regfile_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec_a,
    input  logic             dec_b,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             nz_nxt,
    output logic             underflow
);
    int               sum;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        sum       = int'(cnt) + int'(inc) - int'(dec_a) - int'(dec_b);
        underflow = 1'b0;
        cnt_nxt   = cnt;
        if (sum < 0) begin
            underflow = 1'b1;
            cnt_nxt   = '0;
        end else if (sum > int'(CNT_MAX)) begin
            cnt_nxt   = CNT_MAX;
        end else begin
            cnt_nxt   = CNT_W'(sum);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end

    assign nz     = (cnt != '0);
    assign nz_nxt = (cnt_nxt != '0);
endmodule

// File: rtl/regfile_scoreboard.sv
// RAW/saturation issue gate for the register file plus a drain sequencer; x0 is never tracked.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  sb
);
    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            nz;
    logic [NREG-1:0]            nz_nxt;
    logic [NREG-1:0]            uf;
    logic                       haz1, haz2, sat, ready, fire;
    logic                       run_open, done_pulse;
    logic [31:0]                stall;
    logic                       err_q;
    sb_state_t                  state, state_nxt;

    assign cnt[0]    = '0;
    assign nz[0]     = 1'b0;
    assign nz_nxt[0] = 1'b0;
    assign uf[0]     = 1'b0;

    // A retire landing this cycle on the last pending write is visible to a negedge read.
    assign haz1 = sb.rs1_used && (sb.rs1 != '0) && (cnt[sb.rs1] != '0)
               && !((WB_BYP != 0) && sb.retire_valid && (sb.retire_rd == sb.rs1)
                    && (cnt[sb.rs1] == CNT_W'(1)));
    assign haz2 = sb.rs2_used && (sb.rs2 != '0) && (cnt[sb.rs2] != '0)
               && !((WB_BYP != 0) && sb.retire_valid && (sb.retire_rd == sb.rs2)
                    && (cnt[sb.rs2] == CNT_W'(1)));
    assign sat  = sb.rd_we && (sb.rd != '0) && (cnt[sb.rd] == CNT_MAX);

    assign ready = run_open && !haz1 && !haz2 && !sat;
    assign fire  = sb.issue_valid && ready;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (fire && sb.rd_we && (sb.rd == REG_AW'(r))),
            .dec_a     (sb.retire_valid && (sb.retire_rd == REG_AW'(r))),
            .dec_b     (sb.kill_valid && (sb.kill_rd == REG_AW'(r))),
            .cnt       (cnt[r]),
            .nz        (nz[r]),
            .nz_nxt    (nz_nxt[r]),
            .underflow (uf[r])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SB_RUN;
        else     state <= state_nxt;
    end

    // Completion is judged on post-update counters so the last retire ends the drain.
    always_comb begin
        state_nxt = state;
        case (state)
            SB_RUN:   if (sb.drain_req) state_nxt = SB_DRAIN;
            SB_DRAIN: if (nz_nxt == '0) state_nxt = SB_DONE;
            SB_DONE:  state_nxt = sb.drain_req ? SB_HOLD : SB_RUN;
            SB_HOLD:  if (!sb.drain_req) state_nxt = SB_RUN;
            default:  state_nxt = SB_RUN;
        endcase
    end

    always_comb begin
        run_open   = (state == SB_RUN);
        done_pulse = (state == SB_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall <= '0;
            err_q <= 1'b0;
        end else begin
            if (sb.issue_valid && !ready) stall <= stall + 32'd1;
            if (|uf) err_q <= 1'b1;
        end
    end

    assign sb.issue_ready = ready;
    assign sb.drain_done  = done_pulse;
    assign sb.busy_vec    = nz;
    assign sb.stall_cnt   = stall;
    assign sb.err         = err_q;
endmodule
